ds18b20_poll_sched: RTL and testbench
=====================================

// Module: ds18b20_poll_sched
// PURPOSE
//  Round-robin poll scheduler for up to N_SENS DS18B20 sensors on one 1-wire bus.
//  Per sensor: requests CONVERT_T, waits the conversion time, then requests READ_SCRATCHPAD.
//  Hands the 72-bit scratchpad to the CRC checker and retries on CRC failure.
//  Reports one sample per sensor. Sits between the 1-wire transaction engine and CRC_mod.
// PARAMETERS
//  N_SENS     4       number of sensors polled (1..16)
//  IDXW       2       index width, >= clog2(N_SENS), min 1
//  T_CONV_US  750000  conversion wait, counted in F1M ticks
//  TMO_US     20000   max F1M ticks waiting for ow_done or crc_we
//  MAX_RETRY  2       extra READ attempts after a CRC fail (0..7)
// PORTS
//  clk           in   1     system clock
//  rst           in   1     synchronous, active-high reset
//  F1M           in   1     1 MHz enable strobe, one clk wide; FSM advances only when F1M=1
//  enable        in   1     1 = keep polling; 0 = stop at next IDLE
//  ow_go         out  1     one-clk request pulse to the 1-wire engine
//  ow_cmd        out  1     0 = CONVERT_T, 1 = READ_SCRATCHPAD; stable while ow_busy
//  ow_idx        out  IDXW  sensor addressed; stable while ow_busy
//  ow_busy       in   1     engine busy
//  ow_done       in   1     one-clk completion pulse; scratchpad valid at this point
//  crc_start     out  1     drives CRC check_sum; held high for exactly one F1M tick
//  crc_we        in   1     CRC end-of-check strobe (CRC_mod we)
//  crc_bad       in   1     CRC result level (CRC_mod en_show), 1 = mismatch
//  smp_valid     out  1     one-clk pulse: sample result available
//  smp_idx       out  IDXW  sensor index of the sample
//  smp_ok        out  1     1 = CRC passed; 0 = CRC retries exhausted or timeout
//  err_flags     out  N_SENS  per-sensor error flag
// BEHAVIOUR
//  Reset: state=IDLE, idx=0; all outputs 0 (ow_go, ow_cmd, ow_idx, crc_start, smp_*, err_flags).
//  Mid-operation reset aborts the transaction immediately. The 1-wire engine is not flushed.
//  All state transitions happen only on clk edges where F1M=1. ow_go and smp_valid are single-clk pulses.
//  FSM:
//   IDLE: enable=1 and ow_busy=0 -> CONV_REQ.
//   CONV_REQ: ow_go=1, ow_cmd=0 -> CONV_WAIT. Timer clears.
//   CONV_WAIT: ow_done -> DELAY. Timer reaches TMO_US -> FAIL.
//   DELAY: count T_CONV_US ticks -> READ_REQ.
//   READ_REQ: ow_go=1, ow_cmd=1 -> READ_WAIT.
//   READ_WAIT: ow_done -> CRC_GO. Timeout -> FAIL.
//   CRC_GO: crc_start=1 for one F1M tick -> CRC_WAIT.
//   CRC_WAIT: on a tick with crc_we=1: if crc_bad=0 -> PASS.
//    If crc_bad=1 and retry<MAX_RETRY: retry++, go to READ_REQ.
//    Otherwise -> FAIL. Timeout -> FAIL.
//   PASS: smp_valid, smp_ok=1, err_flags[idx] cleared -> NEXT.
//   FAIL: smp_valid, smp_ok=0, err_flags[idx] set -> NEXT.
//   NEXT: retry=0. idx wraps from N_SENS-1 to 0, otherwise idx+1 -> IDLE.
//  Timers are 20-bit, cleared on every state entry, and saturate rather than wrap.
//  A late ow_done or crc_we arriving in any other state is ignored.
//  enable dropped mid-poll: the current sensor finishes through NEXT, then the FSM holds in IDLE.
//  crc_we and ow_done on the same tick: only the one the current state waits for is used.
//  Latency per sensor, good CRC: 2 + T_CONV_US + 1-wire times + 74 F1M ticks (CRC 72 + start + we).
// CONFIGURATION
//  SCHED_FAILCNT_EN defined:
//   adds output fail_cnt [15:0], a saturating count of CRC mismatches (crc_we & crc_bad in CRC_WAIT).
//   Only rst clears it.
//  SCHED_FAILCNT_EN undefined: no port, no counter; all other behaviour identical.
// TESTING (N_SENS=3, T_CONV_US=10, TMO_US=50, MAX_RETRY=2, F1M every 4 clk)
//  Good path: engine returns ow_done after 5 ticks, crc_we with crc_bad=0.
//   -> sensors 0,1,2 each give smp_ok=1; idx wraps to 0; err_flags=000.
//  Retry: sensor1 crc_bad=1 twice then 0.
//   -> three READ_REQ pulses for idx 1, smp_ok=1; fail_cnt=2 when the macro is enabled.
//  Exhausted: sensor2 crc_bad=1 always.
//   -> 3 READs, smp_valid with smp_ok=0, smp_idx=2, err_flags=100.
//   A later good poll of sensor 2 clears the flag.
//  Timeout: no ow_done on CONVERT for idx 0.
//   -> FAIL at 50 ticks, err_flags[0]=1, next sensor idx 1 is polled.
//  Reset during DELAY and enable low: rst for 1 clk -> all outputs 0, idx=0, no ow_go while enable=0.
//   Raising enable restarts at sensor 0.
//  Stray strobes: ow_done pulse in DELAY -> no state change, no ow_go.

Source files
------------

// File: rtl/ds18b20_poll_sched.sv
// Round-robin CONVERT_T / READ_SCRATCHPAD poll scheduler for DS18B20 sensors
// sharing one 1-wire bus, with CRC retry and a per-sensor error map.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   F1M               1 MHz one-clk enable; the FSM only moves on these ticks
//   enable            keep polling; when low the FSM parks in IDLE
//   ow_go/cmd/idx     request to the 1-wire engine (cmd 0=CONVERT_T, 1=READ)
//   ow_busy/ow_done   engine status and one-clk completion strobe
//   crc_start         CRC check request, high for exactly one F1M tick
//   crc_we/crc_bad    CRC end-of-check strobe and mismatch level
//   smp_valid/idx/ok  one-clk sample report
//   err_flags         per-sensor sticky error, cleared by a good sample
//   fail_cnt          saturating CRC-mismatch counter (SCHED_FAILCNT_EN only)
//
// Build option: define SCHED_FAILCNT_EN to add the fail_cnt output.

module ds18b20_poll_sched #(
    parameter int N_SENS    = 4,
    parameter int IDXW      = 2,
    parameter int T_CONV_US = 750000,
    parameter int TMO_US    = 20000,
    parameter int MAX_RETRY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              F1M,
    input  logic              enable,
    output logic              ow_go,
    output logic              ow_cmd,
    output logic [IDXW-1:0]   ow_idx,
    input  logic              ow_busy,
    input  logic              ow_done,
    output logic              crc_start,
    input  logic              crc_we,
    input  logic              crc_bad,
    output logic              smp_valid,
    output logic [IDXW-1:0]   smp_idx,
    output logic              smp_ok,
    output logic [N_SENS-1:0] err_flags
`ifdef SCHED_FAILCNT_EN
    ,
    output logic [15:0]       fail_cnt
`endif
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_CONV_REQ  = 4'd1;
    localparam logic [3:0] S_CONV_WAIT = 4'd2;
    localparam logic [3:0] S_DELAY     = 4'd3;
    localparam logic [3:0] S_READ_REQ  = 4'd4;
    localparam logic [3:0] S_READ_WAIT = 4'd5;
    localparam logic [3:0] S_CRC_GO    = 4'd6;
    localparam logic [3:0] S_CRC_WAIT  = 4'd7;
    localparam logic [3:0] S_PASS      = 4'd8;
    localparam logic [3:0] S_FAIL      = 4'd9;
    localparam logic [3:0] S_NEXT      = 4'd10;

    // The timer holds the number of ticks already spent in the state, so a
    // limit of L means the L+1-th tick in the state is the deciding one.
    localparam logic [19:0] L_TMO  =
        (TMO_US > 0) ? 20'(TMO_US - 1) : 20'd0;
    localparam logic [19:0] L_CONV =
        (T_CONV_US > 0) ? 20'(T_CONV_US - 1) : 20'd0;
    localparam logic [2:0]  L_RETRY = 3'(MAX_RETRY);
    localparam logic [IDXW-1:0] L_LAST = IDXW'(N_SENS - 1);

    logic [3:0]        r_state;
    logic [3:0]        w_nxt;
    logic [IDXW-1:0]   r_idx;
    logic [2:0]        r_retry;
    logic [19:0]       r_tmr;
    logic              r_done_seen;
    logic              r_we_seen;
    logic              r_bad_seen;
    logic              r_ow_go;
    logic              r_ow_cmd;
    logic [IDXW-1:0]   r_ow_idx;
    logic              r_smp_valid;
    logic [IDXW-1:0]   r_smp_idx;
    logic              r_smp_ok;
    logic [N_SENS-1:0] r_err;

    logic w_ow_wait;
    logic w_done;
    logic w_we;
    logic w_bad;
    logic w_tmo;
    logic w_retry_ok;

    // Strobes from the engine and CRC block may land between F1M ticks;
    // they are remembered until the next tick, but only in the state that
    // is actually waiting for them, so stray strobes elsewhere vanish.
    assign w_ow_wait  = (r_state == S_CONV_WAIT) || (r_state == S_READ_WAIT);
    assign w_done     = r_done_seen | ow_done;
    assign w_we       = r_we_seen | crc_we;
    assign w_bad      = r_we_seen ? r_bad_seen : crc_bad;
    assign w_tmo      = (r_tmr >= L_TMO);
    assign w_retry_ok = (r_retry < L_RETRY);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable && !ow_busy)
                    w_nxt = S_CONV_REQ;
            end
            S_CONV_REQ: w_nxt = S_CONV_WAIT;
            S_CONV_WAIT: begin
                if (w_done)
                    w_nxt = S_DELAY;
                else if (w_tmo)
                    w_nxt = S_FAIL;
            end
            S_DELAY: begin
                if (r_tmr >= L_CONV)
                    w_nxt = S_READ_REQ;
            end
            S_READ_REQ: w_nxt = S_READ_WAIT;
            S_READ_WAIT: begin
                if (w_done)
                    w_nxt = S_CRC_GO;
                else if (w_tmo)
                    w_nxt = S_FAIL;
            end
            S_CRC_GO: w_nxt = S_CRC_WAIT;
            S_CRC_WAIT: begin
                if (w_we) begin
                    if (!w_bad)
                        w_nxt = S_PASS;
                    else if (w_retry_ok)
                        w_nxt = S_READ_REQ;
                    else
                        w_nxt = S_FAIL;
                end else if (w_tmo) begin
                    w_nxt = S_FAIL;
                end
            end
            S_PASS:  w_nxt = S_NEXT;
            S_FAIL:  w_nxt = S_NEXT;
            S_NEXT:  w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_retry     <= '0;
            r_tmr       <= '0;
            r_done_seen <= 1'b0;
            r_we_seen   <= 1'b0;
            r_bad_seen  <= 1'b0;
            r_ow_go     <= 1'b0;
            r_ow_cmd    <= 1'b0;
            r_ow_idx    <= '0;
            r_smp_valid <= 1'b0;
            r_smp_idx   <= '0;
            r_smp_ok    <= 1'b0;
            r_err       <= '0;
        end else begin
            r_ow_go     <= 1'b0;
            r_smp_valid <= 1'b0;

            if (w_ow_wait && ow_done)
                r_done_seen <= 1'b1;
            if ((r_state == S_CRC_WAIT) && crc_we && !r_we_seen) begin
                r_we_seen  <= 1'b1;
                r_bad_seen <= crc_bad;
            end

            if (F1M) begin
                r_state <= w_nxt;
                // Entering a state restarts its timer and forgets strobes.
                if (w_nxt != r_state) begin
                    r_tmr       <= '0;
                    r_done_seen <= 1'b0;
                    r_we_seen   <= 1'b0;
                    r_bad_seen  <= 1'b0;
                end else if (r_tmr != 20'hFFFFF) begin
                    r_tmr <= r_tmr + 20'd1;
                end

                case (r_state)
                    S_CONV_REQ: begin
                        r_ow_go  <= 1'b1;
                        r_ow_cmd <= 1'b0;
                        r_ow_idx <= r_idx;
                    end
                    S_READ_REQ: begin
                        r_ow_go  <= 1'b1;
                        r_ow_cmd <= 1'b1;
                        r_ow_idx <= r_idx;
                    end
                    S_CRC_WAIT: begin
                        if (w_we && w_bad && w_retry_ok)
                            r_retry <= r_retry + 3'd1;
                    end
                    S_PASS: begin
                        r_smp_valid  <= 1'b1;
                        r_smp_ok     <= 1'b1;
                        r_smp_idx    <= r_idx;
                        r_err[r_idx] <= 1'b0;
                    end
                    S_FAIL: begin
                        r_smp_valid  <= 1'b1;
                        r_smp_ok     <= 1'b0;
                        r_smp_idx    <= r_idx;
                        r_err[r_idx] <= 1'b1;
                    end
                    S_NEXT: begin
                        r_retry <= '0;
                        if (r_idx == L_LAST)
                            r_idx <= '0;
                        else
                            r_idx <= r_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ow_go     = r_ow_go;
    assign ow_cmd    = r_ow_cmd;
    assign ow_idx    = r_ow_idx;
    // CRC_GO always lasts until the next tick, so this spans one tick.
    assign crc_start = (r_state == S_CRC_GO);
    assign smp_valid = r_smp_valid;
    assign smp_idx   = r_smp_idx;
    assign smp_ok    = r_smp_ok;
    assign err_flags = r_err;

`ifdef SCHED_FAILCNT_EN
    logic [15:0] r_fail_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_fail_cnt <= '0;
        else if (F1M && (r_state == S_CRC_WAIT) && w_we && w_bad
                 && (r_fail_cnt != 16'hFFFF))
            r_fail_cnt <= r_fail_cnt + 16'd1;
    end

    assign fail_cnt = r_fail_cnt;
`endif

endmodule

// File: tb/tb_ds18b20_poll_sched.sv
// Bench for ds18b20_poll_sched: behavioural 1-wire engine and CRC block,
// per-poll expectations queued at CONVERT time, checked on each sample.

module tb_ds18b20_poll_sched;

    localparam int N_SENS    = 3;
    localparam int IDXW      = 2;
    localparam int T_CONV_US = 10;
    localparam int TMO_US    = 50;
    localparam int MAX_RETRY = 2;
    localparam int N_DIR     = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic F1M = 1'b0;
    logic enable = 1'b0;
    logic ow_busy = 1'b0;
    logic ow_done = 1'b0;
    logic crc_we = 1'b0;
    logic crc_bad = 1'b0;
    logic ow_go;
    logic ow_cmd;
    logic [IDXW-1:0] ow_idx;
    logic crc_start;
    logic smp_valid;
    logic [IDXW-1:0] smp_idx;
    logic smp_ok;
    logic [N_SENS-1:0] err_flags;
`ifdef SCHED_FAILCNT_EN
    logic [15:0] fail_cnt;
`endif

    ds18b20_poll_sched #(
        .N_SENS(N_SENS), .IDXW(IDXW), .T_CONV_US(T_CONV_US),
        .TMO_US(TMO_US), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .F1M(F1M), .enable(enable),
        .ow_go(ow_go), .ow_cmd(ow_cmd), .ow_idx(ow_idx),
        .ow_busy(ow_busy), .ow_done(ow_done),
        .crc_start(crc_start), .crc_we(crc_we), .crc_bad(crc_bad),
        .smp_valid(smp_valid), .smp_idx(smp_idx), .smp_ok(smp_ok),
        .err_flags(err_flags)
`ifdef SCHED_FAILCNT_EN
        , .fail_cnt(fail_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit ok;
        int reads;
        bit tmo;
        int go_tick;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // directed opening: good round, retry / exhausted, timeout, recovery
    int  d_nbad [N_DIR] = '{0, 0, 0, 0, 2, 7, 0, 0, 0};
    bit  d_cdrop[N_DIR] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};

    int tick = 0;
    int div = 0;
    int m_idx = 0;
    int poll_no = 0;
    int eng_cnt = 0;
    bit eng_silent = 0;
    bit eng_conv = 0;
    int crc_cnt = 0;
    bit crc_pend_bad = 0;
    int stray_cnt = 0;
    bit p_conv_drop, p_read_drop, p_crc_drop, p_stray;
    int p_nbad = 0;
    int p_idx = 0;
    int reads = 0;
    int crc_n = 0;
    int go_cnt = 0;
    int smp_cnt = 0;
    int conv_done_cnt = 0;
    int exp_fails = 0;
    bit prev_crc_start = 0;
    logic [N_SENS-1:0] exp_err = '0;

    // Environment: F1M generator, 1-wire engine and CRC block models.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ow_go) begin
                    if (ow_cmd == 1'b0) begin
                        exp_t e;
                        int r;
                        go_cnt++;
                        chk("conv_idx", 32'(ow_idx), 32'(m_idx));
                        if (poll_no < N_DIR) begin
                            p_nbad      = d_nbad[poll_no];
                            p_conv_drop = d_cdrop[poll_no];
                            p_read_drop = 0;
                            p_crc_drop  = 0;
                            p_stray     = (poll_no == 0);
                        end else begin
                            r = int'($urandom_range(0, 99));
                            p_conv_drop = (r < 6);
                            p_read_drop = (r >= 6 && r < 11);
                            p_crc_drop  = (r >= 11 && r < 15);
                            p_nbad = ($urandom_range(0, 1) == 0) ? 0 :
                                     int'($urandom_range(1, 4));
                            if (p_crc_drop)
                                p_nbad = 0;
                            p_stray = ($urandom_range(0, 3) == 0);
                        end
                        poll_no++;
                        p_idx = m_idx;
                        m_idx = (m_idx + 1) % N_SENS;
                        e.idx = p_idx;
                        e.tmo = p_conv_drop;
                        e.go_tick = tick;
                        if (p_conv_drop) begin
                            e.ok = 0; e.reads = 0;
                        end else if (p_read_drop || p_crc_drop) begin
                            e.ok = 0; e.reads = 1;
                        end else if (p_nbad <= MAX_RETRY) begin
                            e.ok = 1; e.reads = p_nbad + 1;
                        end else begin
                            e.ok = 0; e.reads = MAX_RETRY + 1;
                        end
                        sbq.push_back(e);
                        reads = 0;
                        crc_n = 0;
                        eng_cnt = 5;
                        eng_conv = 1;
                        eng_silent = p_conv_drop;
                        ow_busy = 1;
                    end else begin
                        reads++;
                        chk("read_idx", 32'(ow_idx), 32'(p_idx));
                        eng_cnt = 5;
                        eng_conv = 0;
                        eng_silent = p_read_drop && (reads == 1);
                        ow_busy = 1;
                    end
                end
                if (crc_start && !prev_crc_start && !p_crc_drop) begin
                    crc_cnt = 3;
                    crc_pend_bad = (crc_n < p_nbad);
                    if (crc_pend_bad)
                        exp_fails++;
                    crc_n++;
                end
            end
            prev_crc_start = crc_start;
            ow_done = 0;
            crc_we  = 0;
            crc_bad = 0;
            div = (div + 1) % 4;
            F1M = (div == 0);
            if (F1M) begin
                tick++;
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        ow_busy = 0;
                        if (!eng_silent) begin
                            ow_done = 1;
                            if (eng_conv) begin
                                conv_done_cnt++;
                                if (p_stray)
                                    stray_cnt = 3;
                            end
                        end
                    end
                end else if (stray_cnt > 0) begin
                    stray_cnt--;
                    if (stray_cnt == 0)
                        ow_done = 1;
                end
                if (crc_cnt > 0) begin
                    crc_cnt--;
                    if (crc_cnt == 0) begin
                        crc_we  = 1;
                        crc_bad = crc_pend_bad;
                    end
                end
            end
        end
    end

    // Monitor: pops one expectation per reported sample.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && smp_valid) begin
                smp_cnt++;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_sample: got idx %0d expected none",
                             smp_idx);
                end else begin
                    exp_t e;
                    int dt;
                    e = sbq.pop_front();
                    chk("smp_idx", 32'(smp_idx), 32'(e.idx));
                    chk("smp_ok", 32'(smp_ok), 32'(e.ok));
                    chk("read_count", 32'(reads), 32'(e.reads));
                    exp_err[e.idx] = !e.ok;
                    chk("err_flags", 32'(err_flags), 32'(exp_err));
                    if (e.tmo) begin
                        dt = tick - e.go_tick;
                        n_cmp++;
                        if (dt < TMO_US || dt > TMO_US + 2) begin
                            n_bad++;
                            $display("FAIL tmo_ticks: got %0d expected %0d..%0d",
                                     dt, TMO_US, TMO_US + 2);
                        end
                    end
                end
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ow_go"}, 32'(ow_go), 0);
        chk({tag, "_ow_cmd"}, 32'(ow_cmd), 0);
        chk({tag, "_ow_idx"}, 32'(ow_idx), 0);
        chk({tag, "_crc_start"}, 32'(crc_start), 0);
        chk({tag, "_smp_valid"}, 32'(smp_valid), 0);
        chk({tag, "_smp_ok"}, 32'(smp_ok), 0);
        chk({tag, "_smp_idx"}, 32'(smp_idx), 0);
        chk({tag, "_err_flags"}, 32'(err_flags), 0);
    endtask

    task automatic wait_smp(input int n);
        int t;
        t = smp_cnt + n;
        for (int i = 0; i < 30000 && smp_cnt < t; i++)
            @(negedge clk);
        chk("sample_wait", 32'(smp_cnt >= t), 1);
    endtask

    task automatic wait_cnt_change(input string nm, input int which);
        int s;
        int v;
        s = (which == 0) ? go_cnt : conv_done_cnt;
        v = s;
        for (int i = 0; i < 5000 && v == s; i++) begin
            @(negedge clk);
            v = (which == 0) ? go_cnt : conv_done_cnt;
        end
        chk(nm, 32'(v != s), 1);
    endtask

    initial begin
        int g;
        int k;
        rst = 1;
        enable = 0;
        repeat (4) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 0;
        enable = 1;

        wait_smp(N_DIR + 20);

        // enable dropped mid-poll: current sensor completes, then park
        wait_cnt_change("en_drop_go_wait", 0);
        enable = 0;
        k = smp_cnt;
        for (int i = 0; i < 5000 && smp_cnt == k; i++)
            @(negedge clk);
        chk("en_drop_finish", 32'(smp_cnt - k), 1);
        g = go_cnt;
        repeat (240) @(negedge clk);
        chk("en_low_hold", 32'(go_cnt), 32'(g));
        enable = 1;
        wait_smp(3);

        // reset while in DELAY, enable held low afterwards
        wait_cnt_change("delay_wait", 1);
        repeat (8) @(negedge clk);
        enable = 0;
        rst = 1;
        @(negedge clk);
        chk_zero_outputs("midrst");
        sbq.delete();
        m_idx = 0;
        exp_err = '0;
        exp_fails = 0;
        p_crc_drop = 0;
        rst = 0;
        g = go_cnt;
        repeat (160) @(negedge clk);
        chk("rst_en_low_hold", 32'(go_cnt), 32'(g));
        enable = 1;
        wait_smp(6);

        for (int i = 0; i < 3000 && sbq.size() != 0; i++)
            @(negedge clk);
        chk("queue_drained", 32'(sbq.size()), 0);
`ifdef SCHED_FAILCNT_EN
        chk("fail_cnt", 32'(fail_cnt), 32'(exp_fails));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
